// File: rtl/instr_encoder.sv
// instr_encoder: turns symbolic MIPS instructions into 32-bit machine words and
// writes them to consecutive instruction-memory addresses. A NOP delay slot is
// written after every branch/jump when DELAY_SLOT is 1.
//
// Handshakes: a request transfers on a rising edge where in_valid & in_ready;
// a memory write completes on a rising edge where wr_en & wr_ready. While a
// write is pending, wr_en, wr_addr and wr_data hold steady until wr_ready.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int DELAY_SLOT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    SLOT  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t          state_q, state_d;
  logic [31:0]     enc_word, word_q;
  logic            enc_branch, enc_legal, branch_q;
  logic [ADDR_W:0] count_q, free_words;
  logic            space_ok, accept, start, wr_fire;
  logic            err_ill_q, err_ovf_q;

  // Combinational encoder: builds the machine word and classifies the op.
  always_comb begin
    enc_word   = 32'h0;
    enc_branch = 1'b0;
    enc_legal  = 1'b1;
    case (in_op)
      5'd0:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100000};
      5'd1:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100001};
      5'd2:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100010};
      5'd3:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100011};
      5'd4:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100100};
      5'd5:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100101};
      5'd6:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b100111};
      5'd7:  enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'd0, 6'b101010};
      5'd8:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000000};
      5'd9:  enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000010};
      5'd10: enc_word = {6'b000000, 5'd0, in_rt, in_rd, in_shamt, 6'b000011};
      5'd11: begin
        enc_word   = {6'b000000, in_rs, 15'd0, 6'b001000};
        enc_branch = 1'b1;
      end
      5'd12: enc_word = {6'b001100, in_rs, in_rt, in_imm};
      5'd13: enc_word = {6'b001101, in_rs, in_rt, in_imm};
      5'd14: enc_word = {6'b001010, in_rs, in_rt, in_imm};
      5'd15: enc_word = {6'b001000, in_rs, in_rt, in_imm};
      5'd16: enc_word = {6'b001001, in_rs, in_rt, in_imm};
      5'd17: begin
        enc_word   = {6'b000100, in_rs, in_rt, in_imm};
        enc_branch = 1'b1;
      end
      5'd18: begin
        enc_word   = {6'b000101, in_rs, in_rt, in_imm};
        enc_branch = 1'b1;
      end
      5'd19: begin
        enc_word   = {6'b000111, in_rs, 5'd0, in_imm};
        enc_branch = 1'b1;
      end
      5'd20: begin
        enc_word   = {6'b000001, in_rs, 5'd1, in_imm};
        enc_branch = 1'b1;
      end
      5'd21: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      5'd22: enc_word = {6'b101011, in_rs, in_rt, in_imm};
      5'd23: enc_word = {6'b001111, 5'd0, in_rt, in_imm};
      5'd24: begin
        enc_word   = {6'b000011, in_target};
        enc_branch = 1'b1;
      end
      5'd25: begin
        enc_word   = {6'b000010, in_target};
        enc_branch = 1'b1;
      end
      default: enc_legal = 1'b0;
    endcase
  end

  // Space check: a branch with a delay slot needs two free words so the NOP
  // can never be orphaned at the end of memory.
  assign free_words = CAPACITY - count_q;
  assign space_ok   = (enc_branch && DELAY_SLOT != 0) ? (free_words >= (ADDR_W+1)'(2))
                                                      : (free_words >= (ADDR_W+1)'(1));

  assign full      = count_q[ADDR_W];
  assign in_ready  = (state_q == IDLE) && !full;
  assign accept    = in_valid && in_ready;
  assign start     = accept && enc_legal && space_ok;
  assign wr_fire   = wr_en && wr_ready;
  assign wr_addr   = count_q[ADDR_W-1:0];
  assign count     = count_q;
  assign err_illegal  = err_ill_q;
  assign err_overflow = err_ovf_q;
  assign fsm_state    = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and write-port outputs.
  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    wr_data = 32'h0;
    case (state_q)
      IDLE: begin
        if (start) state_d = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_data = word_q;
        if (wr_ready) state_d = (branch_q && DELAY_SLOT != 0) ? SLOT : IDLE;
      end
      SLOT: begin
        wr_en = 1'b1;
        if (wr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: captured word, write counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q    <= 32'h0;
      branch_q  <= 1'b0;
      count_q   <= '0;
      err_ill_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      if (start) begin
        word_q   <= enc_word;
        branch_q <= enc_branch;
      end
      if (wr_fire) count_q <= count_q + 1'b1;
      if (accept && !enc_legal) err_ill_q <= 1'b1;
      if (accept && enc_legal && !space_ok) err_ovf_q <= 1'b1;
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and program loader: the inverse of the pipeline's instruction decoder. It accepts symbolic instructions (operation index plus register, shift, immediate and target fields) over a valid/ready handshake and assembles each into its 32-bit machine word. It writes the words to consecutive instruction-memory addresses and automatically inserts a NOP delay slot after every branch and jump. It sits between the test/boot loader and the instruction-memory write port.

## Interface
- ADDR_W, 8, width of the instruction-memory word address; capacity is 2^ADDR_W words.
- DELAY_SLOT, 1, when 1, a NOP (0x00000000) is written after every branch/jump; when 0, no NOP is inserted.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_op  in  5  operation index: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 NOR, 7 SLT, 8 SLL, 9 SRL, 10 SRA, 11 JR, 12 ANDI, 13 ORI, 14 SLTI, 15 ADDI, 16 ADDIU, 17 BEQ, 18 BNE, 19 BGTZ, 20 BGEZ, 21 LW, 22 SW, 23 LUI, 24 JAL, 25 J; 26-31 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate field.
- in_target  in  26  jump target field.
- wr_en  out  1  memory write request.
- wr_ready  in  1  memory accepts the write this cycle.
- wr_addr  out  ADDR_W  word address.
- wr_data  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written so far.
- full  out  1  all 2^ADDR_W words written.
- err_illegal  out  1  sticky flag: an illegal in_op was accepted.
- err_overflow  out  1  sticky flag: a request was dropped for lack of space.

## Operation
- Encoding formats:
  - R-type: {000000, rs, rt, rd, shamt, funct}.
    - funct values: ADD 100000, ADDU 100001, SUB 100010, SUBU 100011, AND 100100, OR 100101, NOR 100111, SLT 101010, SLL 000000, SRL 000010, SRA 000011, JR 001000.
    - SLL/SRL/SRA force rs=0. They are not treated as branches.
    - JR forces rt=rd=shamt=0.
    - ADD through SLT force shamt=0.
  - I-type: {opcode, rs, rt, imm}.
    - opcodes: ANDI 001100, ORI 001101, SLTI 001010, ADDI 001000, ADDIU 001001, BEQ 000100, BNE 000101, BGTZ 000111, BGEZ 000001, LW 100011, SW 101011, LUI 001111.
    - LUI forces rs=0. BGTZ forces rt=0. BGEZ forces rt=00001.
  - J-type: {opcode, target}, with J 000010 and JAL 000011.
  - Fields not used by a format are ignored.
- Branch class (gets a delay slot when DELAY_SLOT=1): JR, BEQ, BNE, BGTZ, BGEZ, JAL, J.
- States:
  - IDLE: in_ready = ~full; wr_en=0.
  - WRITE: wr_en=1, wr_data=encoded word.
  - SLOT: wr_en=1, wr_data=0.
- Transitions:
  - IDLE -> WRITE on an accept (in_valid & in_ready) of a legal op with enough free space. The encoded word is registered at the accept edge.
  - WRITE -> SLOT on wr_ready if the op is branch class and DELAY_SLOT=1; otherwise WRITE -> IDLE on wr_ready.
  - SLOT -> IDLE on wr_ready.
  - WRITE or SLOT holds while wr_ready=0. wr_addr and wr_data stay stable while held.
- Address: wr_addr = count[ADDR_W-1:0]. count increments by 1 on each wr_en & wr_ready. Addresses never wrap.
- full is asserted when count == 2^ADDR_W.
- Required space: 2 free words for a branch-class op when DELAY_SLOT=1; otherwise 1.
- Accepted request with an illegal op: nothing is written; err_illegal is set; state stays IDLE.
- Accepted branch with exactly one free word: nothing is written; err_overflow is set.
- Error flags stay set until reset.

## Timing
- Reset values: state IDLE, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err_illegal=0, err_overflow=0. in_ready=1 in the first cycle after reset.
- Latency: accept at edge N -> wr_en=1 during cycle N+1.
- Throughput with wr_ready held high: one plain instruction per 2 cycles; one branch (word + NOP) per 3 cycles.
- in_ready is 0 in WRITE and SLOT. in_ready depends only on state and full, never on in_op.
- Reset asserted mid-write: the write is abandoned, wr_en=0 after the reset edge, and count returns to 0.

## Test plan
- Reset, then ADD rs=1 rt=2 rd=3 with wr_ready=1 -> wr_data=0x00221820 at wr_addr 0 in cycle N+1; count=1.
- ADDI rt=5 imm=0x0010, then LUI rt=4 imm=0x1234, then SLL rt=2 rd=3 shamt=4 -> 0x20050010, 0x3C041234, 0x00021900 at addresses 0, 1, 2.
- BEQ rs=1 rt=2 imm=3, then J target=0x10 -> 0x10220003 at 0, NOP at 1, 0x08000010 at 2, NOP at 3; count=4. With DELAY_SLOT=0 -> count=2.
- BGEZ rs=3 imm=0xFFFF with wr_ready low for 3 cycles -> wr_data=0x0461FFFF and wr_addr held stable; in_ready=0 throughout; completes once wr_ready rises.
- in_op=27 -> no wr_en, err_illegal=1, count unchanged. ADD sent next is still written correctly.
- ADDR_W=2: fill 3 words, then send BNE -> err_overflow=1, nothing written. One more ADD -> full=1, in_ready=0. Reset -> count=0 and both error flags clear.
